// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words out of the FIFO read side.
interface fifo_rd_stream_if #(
    parameter int DATASIZE = 8
);
    logic [DATASIZE-1:0] m_data;
    logic                m_valid;
    logic                m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async FIFO read engine: Gray read pointer, empty detect, registered-RAM
// read port and a 2-entry skid buffer feeding a valid/ready stream.
module fifo_rd_stream #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] mem_raddr,
    output logic                mem_rinc,
    input  logic [DATASIZE-1:0] mem_rdata,
    fifo_rd_stream_if.master    strm,
    output logic                rempty
);

    logic [ADDRSIZE:0]   r_rbin;
    logic [ADDRSIZE:0]   r_rptr;
    logic                r_inflight;
    logic [1:0]          r_cnt;
    logic [DATASIZE-1:0] r_buf0;
    logic [DATASIZE-1:0] r_buf1;

    logic                w_mem_empty;
    logic                w_valid;
    logic                w_pop;
    logic [2:0]          w_occ;
    logic                w_issue;
    logic [ADDRSIZE:0]   w_rbin_nxt;

    assign w_mem_empty = (r_rptr == rq2_wptr);
    assign w_valid     = (r_cnt != 2'd0);
    assign w_pop       = w_valid & strm.m_ready;
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight}
                       - {2'b00, w_pop};
    assign w_issue     = rrst_n & ~w_mem_empty & (w_occ < 3'd2);
    assign w_rbin_nxt  = r_rbin + 1'b1;

    assign mem_rinc     = w_issue;
    assign mem_raddr    = r_rbin[ADDRSIZE-1:0];
    assign rptr         = r_rptr;
    assign strm.m_valid = w_valid;
    assign strm.m_data  = r_buf0;
    // Reported empty while held in reset, whatever the write pointer shows.
    assign rempty = ~rrst_n
                  | (w_mem_empty & ~r_inflight & (r_cnt == 2'd0));

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_issue;
            r_cnt      <= w_occ[1:0];
            if (w_issue) begin
                r_rbin <= w_rbin_nxt;
                r_rptr <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
            end
            // Head leaves before the arriving word is appended.
            case ({w_pop, r_inflight})
                2'b11: begin
                    if (r_cnt == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= mem_rdata;
                    end else begin
                        r_buf0 <= mem_rdata;
                    end
                end
                2'b10: r_buf0 <= r_buf1;
                2'b01: begin
                    if (r_cnt == 2'd0) r_buf0 <= mem_rdata;
                    else               r_buf1 <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (
        @(posedge rclk) disable iff (!rrst_n) w_occ <= 3'd2
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a registered-RAM model
// and a simple write-pointer model.
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic [AW:0]   rq2_wptr = '0;
    logic [AW:0]   rptr;
    logic [AW-1:0] mem_raddr;
    logic          mem_rinc;
    logic [DW-1:0] mem_rdata = '0;
    logic          rempty;

    fifo_rd_stream_if #(.DATASIZE(DW)) strm ();

    fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rq2_wptr  (rq2_wptr),
        .rptr      (rptr),
        .mem_raddr (mem_raddr),
        .mem_rinc  (mem_rinc),
        .mem_rdata (mem_rdata),
        .strm      (strm.master),
        .rempty    (rempty)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [16];

    always @(posedge rclk) begin
        if (mem_rinc) mem_rdata <= mem[mem_raddr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        rq2_wptr = '0;
        strm.m_ready = 1'b0;
        step();
        step();
        rrst_n = 1'b1;
    endtask

    initial begin
        int w, pulses, got, wcnt, rcvd, iss;
        logic saw_raddr_wrap, saw_rptr_wrap;
        logic [AW:0] prev;

        strm.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset held while inputs wiggle
        for (int i = 0; i < 4; i++) begin
            step();
            strm.m_ready = i[0];
            rq2_wptr = gray(i + 1);
            #1;
            chk("rst_rptr", 32'(rptr), 0);
            chk("rst_rinc", 32'(mem_rinc), 0);
            chk("rst_valid", 32'(strm.m_valid), 0);
            chk("rst_empty", 32'(rempty), 1);
        end
        step();
        rrst_n = 1'b1;
        rq2_wptr = '0;
        strm.m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rel_rptr", 32'(rptr), 0);
            chk("rel_rinc", 32'(mem_rinc), 0);
            chk("rel_valid", 32'(strm.m_valid), 0);
            chk("rel_empty", 32'(rempty), 1);
            step();
        end

        // Single word
        mem[0] = 8'hA5;
        rq2_wptr = gray(1);
        strm.m_ready = 1'b1;
        #1;
        chk("sw_rinc0", 32'(mem_rinc), 1);
        chk("sw_raddr0", 32'(mem_raddr), 0);
        chk("sw_empty0", 32'(rempty), 0);
        chk("sw_valid0", 32'(strm.m_valid), 0);
        step(); #1;
        chk("sw_rptr1", 32'(rptr), 32'h01);
        chk("sw_rinc1", 32'(mem_rinc), 0);
        chk("sw_valid1", 32'(strm.m_valid), 0);
        chk("sw_empty1", 32'(rempty), 0);
        step(); #1;
        chk("sw_valid2", 32'(strm.m_valid), 1);
        chk("sw_data2", 32'(strm.m_data), 32'hA5);
        step(); #1;
        chk("sw_valid3", 32'(strm.m_valid), 0);
        chk("sw_empty3", 32'(rempty), 1);

        // Full-rate burst of 16
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        rq2_wptr = 5'b11000;
        strm.m_ready = 1'b1;
        #1;
        chk("bu_rinc0", 32'(mem_rinc), 1);
        w = 0;
        while (!strm.m_valid && w < 6) begin
            step(); #1;
            w++;
        end
        chk("bu_latency", 32'(w), 2);
        for (int i = 0; i < 16; i++) begin
            chk("bu_valid", 32'(strm.m_valid), 1);
            chk("bu_data", 32'(strm.m_data), 32'(i));
            step(); #1;
        end
        chk("bu_valid_end", 32'(strm.m_valid), 0);
        chk("bu_rptr_end", 32'(rptr), 32'h18);
        chk("bu_empty_end", 32'(rempty), 1);

        // Backpressure
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'(8'h30 + i);
        rq2_wptr = gray(4);
        strm.m_ready = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (mem_rinc) pulses++;
            if (c >= 2) begin
                chk("bp_valid", 32'(strm.m_valid), 1);
                chk("bp_hold", 32'(strm.m_data), 32'h30);
            end
            step();
        end
        chk("bp_pulses", 32'(pulses), 2);
        chk("bp_cnt", 32'(dut.r_cnt), 2);
        strm.m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (strm.m_valid && strm.m_ready) begin
                chk("bp_data", 32'(strm.m_data), 32'(8'h30 + got));
                got++;
            end
            step();
        end
        chk("bp_count", 32'(got), 4);
        chk("bp_empty", 32'(rempty), 1);

        // Wrap-around with random ready
        do_reset();
        wcnt = 0; rcvd = 0; iss = 0;
        saw_raddr_wrap = 1'b0;
        saw_rptr_wrap = 1'b0;
        prev = '0;
        for (int c = 0; c < 600 && rcvd < 40; c++) begin
            if (wcnt < 40 && (wcnt - rcvd) < 16) begin
                mem[wcnt % 16] = 8'(8'h40 + wcnt);
                wcnt++;
                rq2_wptr = gray(wcnt);
            end
            strm.m_ready = 1'($urandom_range(0, 1));
            #1;
            chk("wr_rptr", 32'(rptr), 32'(gray(iss)));
            if (rptr != prev) begin
                chk("wr_gray1", 32'($countones(rptr ^ prev)), 1);
                if (prev == 5'b10000 && rptr == 5'b00000)
                    saw_rptr_wrap = 1'b1;
                prev = rptr;
            end
            if (mem_rinc) begin
                chk("wr_raddr", 32'(mem_raddr), 32'(iss % 16));
                if (iss > 0 && iss % 16 == 0) saw_raddr_wrap = 1'b1;
                iss++;
            end
            if (strm.m_valid && strm.m_ready) begin
                chk("wr_data", 32'(strm.m_data), 32'(8'h40 + rcvd));
                rcvd++;
            end
            step();
        end
        chk("wr_count", 32'(rcvd), 40);
        chk("wr_issues", 32'(iss), 40);
        chk("wr_raddr_wrap", 32'(saw_raddr_wrap), 1);
        chk("wr_rptr_wrap", 32'(saw_rptr_wrap), 1);

        // Reset mid-stream with a full buffer
        do_reset();
        for (int i = 0; i < 4; i++) mem[i] = 8'(8'h50 + i);
        rq2_wptr = gray(4);
        strm.m_ready = 1'b0;
        step(); step(); step();
        #1;
        chk("mr_cnt", 32'(dut.r_cnt), 2);
        chk("mr_valid_pre", 32'(strm.m_valid), 1);
        chk("mr_rptr_pre", 32'(rptr), 32'h03);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(strm.m_valid), 0);
        chk("mr_rptr", 32'(rptr), 0);
        chk("mr_empty", 32'(rempty), 1);
        chk("mr_rinc", 32'(mem_rinc), 0);
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            chk("mr_rinc_hold", 32'(mem_rinc), 0);
            chk("mr_valid_hold", 32'(strm.m_valid), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
